// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared mode encoding, occupancy states and the width-generic extension function.
// Used by imm_ext_core and imm_extend_pipe; optional IMM_EXT_ERR_CNT_EN lives in the top.
package imm_ext_pkg;

    localparam int IMM_SRC_W = 3;
    localparam int EXT_MAX_W = 64;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_ZX_S = 3'd0,
        IMM_ZX_L = 3'd1,
        IMM_SX_S = 3'd2,
        IMM_SX_L = 3'd3,
        IMM_UP   = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_e;

    function automatic logic imm_src_illegal(input logic [IMM_SRC_W-1:0] src);
        return src > IMM_UP;
    endfunction

    // Works on a 64-bit carrier; the caller truncates to its own XLEN.
    function automatic logic [EXT_MAX_W-1:0] imm_ext(
        input logic [EXT_MAX_W-1:0] imm,
        input logic [IMM_SRC_W-1:0] src,
        input int                   xlen,
        input int                   imm_w,
        input int                   short_w
    );
        logic [EXT_MAX_W-1:0] mask_s;
        logic [EXT_MAX_W-1:0] mask_l;
        mask_s = (64'd1 << short_w) - 64'd1;
        mask_l = (64'd1 << imm_w) - 64'd1;
        return src == IMM_ZX_S ? imm & mask_s :
               src == IMM_ZX_L ? imm & mask_l :
               src == IMM_SX_S ? (imm[6'(short_w - 1)] ? imm | ~mask_s : imm & mask_s) :
               src == IMM_SX_L ? (imm[6'(imm_w - 1)] ? imm | ~mask_l : imm & mask_l) :
               src == IMM_UP   ? (imm & mask_l) << (xlen - imm_w) :
                                 '0;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: valid/ready request and response bundle for the pipelined immediate extender.
interface imm_extend_pipe_if
    import imm_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 25
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [IMM_SRC_W-1:0] imm_src;
    logic [IMM_W-1:0]     imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      result;
    logic                 out_err;

    modport master (
        output in_valid, imm_src, imm, out_ready,
        input  in_ready, out_valid, result, out_err
    );

    modport slave (
        input  in_valid, imm_src, imm, out_ready,
        output in_ready, out_valid, result, out_err
    );

endinterface

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational mode decode and extension of one immediate to XLEN bits.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IMM_W   = 25,
    parameter int SHORT_W = 15
) (
    input  logic [IMM_SRC_W-1:0] imm_src_i,
    input  logic [IMM_W-1:0]     imm_i,
    output logic [XLEN-1:0]      result_o,
    output logic                 err_o
);

    logic [EXT_MAX_W-1:0] ext;
    logic                 unused_ext;

    assign ext        = imm_ext(EXT_MAX_W'(imm_i), imm_src_i, XLEN, IMM_W, SHORT_W);
    assign result_o   = ext[XLEN-1:0];
    assign err_o      = imm_src_illegal(imm_src_i);
    assign unused_ext = ^ext;

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: 1-cycle immediate extender with 2-entry skid buffer; in_ready depends on occupancy only.
// Define IMM_EXT_ERR_CNT_EN to add the saturating illegal-select counter err_count.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IMM_W   = 25,
    parameter int SHORT_W = 15
) (
    input  logic clk,
    input  logic rst,
    imm_extend_pipe_if.slave bus
`ifdef IMM_EXT_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    occ_e            state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_err_q;
    logic            skid_err_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] skid_q;
    logic [XLEN-1:0] ext;
    logic            ext_err;
    logic            in_xfer;
    logic            out_xfer;

    imm_ext_core #(
        .XLEN    (XLEN),
        .IMM_W   (IMM_W),
        .SHORT_W (SHORT_W)
    ) u_core (
        .imm_src_i (bus.imm_src),
        .imm_i     (bus.imm),
        .result_o  (ext),
        .err_o     (ext_err)
    );

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            skid_err_q  <= 1'b0;
            result_q    <= '0;
            skid_q      <= '0;
        end else begin
            case (state_q)
                OCC_EMPTY: if (in_xfer) begin
                    result_q    <= ext;
                    out_err_q   <= ext_err;
                    out_valid_q <= 1'b1;
                    state_q     <= OCC_ONE;
                end
                OCC_ONE: if (in_xfer && out_xfer) begin
                    result_q  <= ext;
                    out_err_q <= ext_err;
                end else if (in_xfer) begin
                    skid_q     <= ext;
                    skid_err_q <= ext_err;
                    in_ready_q <= 1'b0;
                    state_q    <= OCC_TWO;
                end else if (out_xfer) begin
                    out_valid_q <= 1'b0;
                    state_q     <= OCC_EMPTY;
                end
                // TWO only ever drains: the skid entry is promoted and input reopens.
                OCC_TWO: if (out_xfer) begin
                    result_q   <= skid_q;
                    out_err_q  <= skid_err_q;
                    in_ready_q <= 1'b1;
                    state_q    <= OCC_ONE;
                end
                default: begin
                    state_q     <= OCC_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.out_err   = out_err_q;

`ifdef IMM_EXT_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;

    always_comb err_cnt_d = in_xfer && ext_err && err_cnt_q != 16'hFFFF ? err_cnt_q + 16'd1 : err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed and random checks of imm_extend_pipe against a FIFO-occupancy reference model.
module tb_imm_extend_pipe;

    localparam int XLEN    = 32;
    localparam int IMM_W   = 25;
    localparam int SHORT_W = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] exp_res_q[$];
    logic        exp_err_q[$];
    logic [15:0] exp_cnt = '0;
    logic        last_in_x = 1'b0;

    imm_extend_pipe_if #(.XLEN(XLEN), .IMM_W(IMM_W)) bus ();

`ifdef IMM_EXT_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    imm_extend_pipe #(
        .XLEN    (XLEN),
        .IMM_W   (IMM_W),
        .SHORT_W (SHORT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IMM_EXT_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [24:0] v, input logic [2:0] s);
        logic signed [14:0] ss;
        logic signed [24:0] ls;
        ss = v[14:0];
        ls = v;
        case (s)
            3'd0:    return 32'(v[14:0]);
            3'd1:    return 32'(v);
            3'd2:    return 32'(ss);
            3'd3:    return 32'(ls);
            3'd4:    return {v, 7'b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the DUT at the falling edge, then advances the model across the next rising edge.
    task automatic cycle();
        logic exp_ov;
        logic exp_rdy;
        logic in_x;
        @(negedge clk);
        exp_ov  = exp_res_q.size() > 0;
        exp_rdy = exp_res_q.size() < 2;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, exp_ov);
        if (exp_ov) begin
            chk("result", bus.result, exp_res_q[0]);
            chk("out_err", bus.out_err, exp_err_q[0]);
        end
`ifdef IMM_EXT_ERR_CNT_EN
        chk("err_count", err_count, exp_cnt);
`endif
        in_x = bus.in_valid && exp_rdy;
        if (exp_ov && bus.out_ready) begin
            void'(exp_res_q.pop_front());
            void'(exp_err_q.pop_front());
        end
        if (in_x) begin
            exp_res_q.push_back(model(bus.imm, bus.imm_src));
            exp_err_q.push_back(bus.imm_src > 3'd4);
            if (bus.imm_src > 3'd4 && exp_cnt != 16'hFFFF) exp_cnt++;
        end
        last_in_x = in_x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [24:0] a;
        logic        pend;
        int          sent;
        bus.in_valid  = 1'b0;
        bus.imm_src   = '0;
        bus.imm       = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_out_err", bus.out_err, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef IMM_EXT_ERR_CNT_EN
        chk("rst_err_count", err_count, 16'd0);
`endif
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.imm       = 25'h0004000;
        bus.imm_src   = 3'd0;
        cycle();
        chk("zx_s", bus.result, 32'h00004000);
        bus.imm_src = 3'd2;
        cycle();
        chk("sx_s", bus.result, 32'hFFFFC000);
        chk("sx_s_err", bus.out_err, 1'b0);
        bus.imm     = 25'h1000001;
        bus.imm_src = 3'd1;
        cycle();
        chk("zx_l", bus.result, 32'h01000001);
        bus.imm_src = 3'd3;
        cycle();
        chk("sx_l", bus.result, 32'hFF000001);
        bus.imm_src = 3'd4;
        cycle();
        chk("up", bus.result, 32'h80000080);
        bus.imm     = 25'h1FFFFFF;
        bus.imm_src = 3'd6;
        cycle();
        chk("illegal_res", bus.result, 32'd0);
        chk("illegal_err", bus.out_err, 1'b1);
`ifdef IMM_EXT_ERR_CNT_EN
        chk("err_count_one", err_count, 16'd1);
`endif
        bus.in_valid = 1'b0;
        repeat (2) cycle();
        // Backpressure: fill both entries, hold C off, then drain in order.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.imm       = 25'h0000AAA;
        bus.imm_src   = 3'd1;
        cycle();
        bus.imm     = 25'h0012345;
        bus.imm_src = 3'd3;
        cycle();
        chk("bp_in_ready", bus.in_ready, 1'b0);
        bus.imm     = 25'h1ABCDEF;
        bus.imm_src = 3'd2;
        repeat (3) cycle();
        chk("bp_hold_a", bus.result, 32'h00000AAA);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_b", bus.result, 32'h00012345);
        cycle();
        bus.in_valid = 1'b0;
        chk("bp_c", bus.result, 32'hFFFFCDEF);
        repeat (2) cycle();
        // Async reset while both entries are occupied.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.imm_src   = 3'd0;
        repeat (2) cycle();
        bus.in_valid = 1'b0;
        chk("two_in_ready", bus.in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_result", bus.result, 32'd0);
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
        exp_res_q.delete();
        exp_err_q.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.imm       = 25'h0007FFF;
        bus.imm_src   = 3'd2;
        cycle();
        chk("post_rst_lat", bus.result, 32'hFFFFFFFF);
        bus.in_valid = 1'b0;
        cycle();
        // Random valid/ready traffic; the source holds data until accepted.
        sent = 0;
        pend = 1'b0;
        while (sent < 1000) begin
            if (!pend) begin
                bus.in_valid = $urandom_range(0, 3) != 0;
                a = 25'($urandom);
                bus.imm     = a;
                bus.imm_src = 3'($urandom_range(0, 7));
            end
            bus.out_ready = $urandom_range(0, 2) != 0;
            cycle();
            if (last_in_x) sent++;
            pend = bus.in_valid && !last_in_x;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cycle();
        chk("drain_empty", 64'(exp_res_q.size()), 64'd0);
`ifdef IMM_EXT_ERR_CNT_EN
        bus.in_valid = 1'b1;
        bus.imm_src  = 3'd7;
        repeat (65540) cycle();
        bus.in_valid = 1'b0;
        cycle();
        chk("err_count_sat", err_count, 16'hFFFF);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Pipelined, parametrised immediate-extension unit for the decode stage. It replaces the purely combinational extender.
- Takes one immediate field plus a mode select and produces an XLEN-bit operand.
- Modes: zero-extend, sign-extend and upper-placement, each for the short or long immediate as applicable.
- Valid/ready handshake on both sides, 1-cycle latency, 2-entry skid buffer so full throughput is kept under backpressure.
- Illegal mode selects are flagged per result.

Parameters:
- XLEN, 32, output operand width.
- IMM_W, 25, long immediate width; the short immediate is imm[SHORT_W-1:0]. Must satisfy SHORT_W < IMM_W <= XLEN.
- SHORT_W, 15, short immediate width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  imm/imm_src valid.
- in_ready  out  1  unit can accept; registered.
- imm_src  in  3  mode select.
- imm  in  IMM_W  raw immediate field.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- result  out  XLEN  extended operand.
- out_err  out  1  result came from an illegal imm_src.
- err_count  out  16  saturating illegal-select count; present only with IMM_EXT_ERR_CNT_EN.

Behaviour:
- Reset (async, rst=1): out_valid=0, result=0, out_err=0, in_ready=1, skid empty, err_count=0.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, result and out_err hold stable.
- Mode encoding (imm_src):
  - 0: zero-extend imm[SHORT_W-1:0].
  - 1: zero-extend imm[IMM_W-1:0].
  - 2: sign-extend imm[SHORT_W-1:0] using bit SHORT_W-1.
  - 3: sign-extend imm using bit IMM_W-1.
  - 4: upper placement, {imm, (XLEN-IMM_W) zeros}; if IMM_W==XLEN, result=imm.
  - 5..7: result=0, out_err=1.
- Codes 0 and 1 match the previous extender exactly.
- Extension is computed combinationally from the inputs and registered on input transfer.
- State machine (occupancy):
  - EMPTY: out_valid=0. On input transfer -> ONE.
  - ONE: output reg valid.
    - Input and output transfer together -> ONE (output reg reloads).
    - Input only -> TWO (new data goes to skid; in_ready falls next cycle).
    - Output only -> EMPTY.
  - TWO: output and skid regs valid, in_ready=0.
    - On output transfer, skid moves to output reg -> ONE, in_ready=1 next cycle.
    - No input is accepted in TWO.
- in_ready is 1 in EMPTY and ONE, 0 in TWO. It depends only on state, never combinationally on out_ready.
- Ordering: results leave strictly in acceptance order. No drops, no duplicates.
- Latency: input accepted at edge N gives out_valid=1 after edge N when EMPTY or ONE-with-drain.
- Throughput: 1 result/cycle with out_ready held high.
- Simultaneous in and out transfer in ONE: the output reg takes the new data, and the old data counts as consumed.
- in_valid while in_ready=0 is ignored; the source must hold the data.
- Reset mid-operation flushes all entries with no output transfer. Pending data is lost by design.

Optional Feature:
- Macro IMM_EXT_ERR_CNT_EN.
- Defined:
  - err_count port exists.
  - Increments by 1 on each input transfer with imm_src in 5..7.
  - Saturates at 16'hFFFF; rst clears it.
- Undefined:
  - Port and counter are absent.
  - out_err still works.

Decomposition:
- Shared package imm_ext_pkg:
  - imm_src_e enum (IMM_ZX_S=0, IMM_ZX_L=1, IMM_SX_S=2, IMM_SX_L=3, IMM_UP=4).
  - IMM_SRC_W=3.
  - Function for pure extension, parametrised by widths.
- One natural sub-module, imm_ext_core: the combinational mode decode/extend, used by the pipe.
- The skid/occupancy logic stays in imm_extend_pipe.

Test Plan (XLEN=32, IMM_W=25, SHORT_W=15):
- imm=25'h0004000, out_ready=1, src 0 then 2 -> results 32'h00004000, 32'hFFFFC000 on consecutive cycles, out_err=0.
- imm=25'h1000001, src 1, 3, 4 back-to-back -> 32'h01000001, 32'hFF000001, 32'h80000080, one per cycle.
- src=6, imm=25'h1FFFFFF -> result=0, out_err=1; with IMM_EXT_ERR_CNT_EN, err_count 0->1. Force 65536 illegal inputs -> err_count stays 16'hFFFF.
- Backpressure: out_ready=0, push A,B -> in_ready=0 after B, C held off. Raise out_ready -> A,B,C emerge in order, with result stable while stalled.
- Random valid/ready toggling over 1000 items against a scoreboard -> no loss, reorder or duplication.
- Assert rst while in TWO -> out_valid=0, result=0, in_ready=1 immediately. After release, the next input emerges with 1-cycle latency.
